digit_serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor.
- Adds two WIDTH-bit operands CHUNK bits per clock. The carry is held in a register between chunks, so one narrow adder slice is reused instead of a full-width ripple chain.
- Adds subtract mode, signed-overflow detection and a valid/ready handshake.
- Sits in the datapath where area matters more than latency. It is the sequential successor to the fixed-width combinational ripple adders.

---
 rtl/digit_serial_adder.sv | 120 ++++++++++++
 tb/tb_digit_serial_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one CHUNK-bit adder slice is reused over
// WIDTH/CHUNK clocks, with the carry kept in a register between chunks.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_r, b_r, sum_r, sum_shift;
    logic              carry_r, carry_out_r, overflow_r;
    logic [CW-1:0]     cnt;
    logic [CHUNK:0]    slice;
    logic              last;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Carry into the slice MSB is recovered from its operand and sum bits.
    function automatic logic msb_carry_in(input logic x, input logic y, input logic s);
        return x ^ y ^ s;
    endfunction

    assign slice = chunk_add(a_r[CHUNK-1:0], b_r[CHUNK-1:0], carry_r);
    assign last  = (cnt == CW'(NCHUNK - 1));

    generate
        if (CHUNK == WIDTH) begin : g_full
            assign sum_shift = slice[CHUNK-1:0];
        end else begin : g_part
            assign sum_shift = {slice[CHUNK-1:0], sum_r[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow_in.
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ^ carry_in;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    sum_r   <= sum_shift;
                    carry_r <= slice[CHUNK];
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        carry_out_r <= slice[CHUNK];
                        overflow_r  <= msb_carry_in(a_r[CHUNK-1], b_r[CHUNK-1],
                                                    slice[CHUNK-1]) ^ slice[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: five parameterisations checked against an
// integer-arithmetic model, plus directed handshake and reset scenarios.
module tb_digit_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_in = '0, b_in = '0;
    logic        cin = 1'b0, sub_s = 1'b0;
    logic [4:0]  iv = '0, ordy = '0;
    logic [4:0]  ir, ov, co, of, bz;
    logic [15:0] s0, s1, s2, s3;
    logic [31:0] s4;
    logic [31:0] sum_w [5];

    int errors = 0;
    int checks = 0;
    int wid [5] = '{16, 16, 16, 16, 32};
    int nch [5] = '{16, 4, 2, 1, 4};

    logic [4:0]  pending = '0;
    logic [31:0] exp_sum [5];
    logic        exp_co  [5];
    logic        exp_of  [5];

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .CHUNK(1)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_in[15:0]), .b(b_in[15:0]), .carry_in(cin), .sub(sub_s), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s0), .carry_out(co[0]), .overflow(of[0]), .busy(bz[0]));
    digit_serial_adder #(.WIDTH(16), .CHUNK(4)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_in[15:0]), .b(b_in[15:0]), .carry_in(cin), .sub(sub_s), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .carry_out(co[1]), .overflow(of[1]), .busy(bz[1]));
    digit_serial_adder #(.WIDTH(16), .CHUNK(8)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_in[15:0]), .b(b_in[15:0]), .carry_in(cin), .sub(sub_s), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s2), .carry_out(co[2]), .overflow(of[2]), .busy(bz[2]));
    digit_serial_adder #(.WIDTH(16), .CHUNK(16)) u3 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_in[15:0]), .b(b_in[15:0]), .carry_in(cin), .sub(sub_s), .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum(s3), .carry_out(co[3]), .overflow(of[3]), .busy(bz[3]));
    digit_serial_adder #(.WIDTH(32), .CHUNK(8)) u4 (.clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
        .a(a_in), .b(b_in), .carry_in(cin), .sub(sub_s), .out_valid(ov[4]), .out_ready(ordy[4]),
        .sum(s4), .carry_out(co[4]), .overflow(of[4]), .busy(bz[4]));

    assign sum_w[0] = {16'h0, s0};
    assign sum_w[1] = {16'h0, s1};
    assign sum_w[2] = {16'h0, s2};
    assign sum_w[3] = {16'h0, s3};
    assign sum_w[4] = s4;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input longint ua, input longint ub, input bit c,
                                  input bit s, output longint rs, output bit rco, output bit rov);
        longint m, h, t, sa, sb, r;
        m = longint'(1) << w;
        h = m >> 1;
        if (!s) begin
            t   = ua + ub + longint'(c);
            rco = (t >= m);
        end else begin
            t   = ua - ub - longint'(c);
            rco = (t >= 0);
        end
        rs  = t & (m - 1);
        sa  = (ua >= h) ? ua - m : ua;
        sb  = (ub >= h) ? ub - m : ub;
        r   = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
        rov = (r >= h) || (r < -h);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Output checker: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                if (ov[i]) begin
                    if (!pending[i]) begin
                        chk($sformatf("spurious_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
                    end else begin
                        chk($sformatf("sum[%0d]", i), sum_w[i], exp_sum[i]);
                        chk($sformatf("carry_out[%0d]", i), 32'(co[i]), 32'(exp_co[i]));
                        chk($sformatf("overflow[%0d]", i), 32'(of[i]), 32'(exp_of[i]));
                        chk($sformatf("in_ready_in_done[%0d]", i), 32'(ir[i]), 32'd0);
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input int i);
        chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
        chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
        chk($sformatf("rst_busy[%0d]", i), 32'(bz[i]), 32'd0);
        chk($sformatf("rst_sum[%0d]", i), sum_w[i], 32'd0);
        chk($sformatf("rst_carry_out[%0d]", i), 32'(co[i]), 32'd0);
        chk($sformatf("rst_overflow[%0d]", i), 32'(of[i]), 32'd0);
    endtask

    task automatic run_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                          input bit c, input bit s, input int hold, input bit noise);
        longint rs;
        bit rco, rov;
        int lat;
        logic [31:0] mask;
        mask = (wid[idx] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        model(wid[idx], longint'(av & mask), longint'(bv & mask), c, s, rs, rco, rov);
        @(negedge clk);
        chk($sformatf("accept_ready[%0d]", idx), 32'(ir[idx]), 32'd1);
        a_in = av; b_in = bv; cin = c; sub_s = s;
        iv[idx] = 1'b1;
        @(posedge clk);
        #1;
        iv[idx] = 1'b0;
        exp_sum[idx] = 32'(rs);
        exp_co[idx]  = rco;
        exp_of[idx]  = rov;
        pending[idx] = 1'b1;
        chk($sformatf("busy_after_accept[%0d]", idx), 32'(bz[idx]), 32'd1);
        lat = 0;
        while (!ov[idx] && lat <= 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(nch[idx]));
        for (int k = 0; k < hold; k++) begin
            if (noise) begin
                iv[idx] = ~iv[idx];
                a_in = $urandom; b_in = $urandom; cin = 1'($urandom); sub_s = 1'($urandom);
            end
            @(posedge clk);
            #1;
            chk($sformatf("hold_valid[%0d]", idx), 32'(ov[idx]), 32'd1);
            chk($sformatf("hold_in_ready[%0d]", idx), 32'(ir[idx]), 32'd0);
        end
        iv[idx] = 1'b0;
        ordy[idx] = 1'b1;
        @(posedge clk);
        #1;
        ordy[idx] = 1'b0;
        pending[idx] = 1'b0;
        chk($sformatf("drain_valid[%0d]", idx), 32'(ov[idx]), 32'd0);
        chk($sformatf("drain_ready[%0d]", idx), 32'(ir[idx]), 32'd1);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return m;
            2:       return (m >> 1) + 32'h1;
            3:       return m >> 1;
            default: return $urandom & m;
        endcase
    endfunction

    initial begin
        longint rs;
        bit rco, rov;

        // Pin the model to hand-computed results.
        model(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0, rs, rco, rov);
        chk("model_ffff_plus_1", {32'(rs[15:0]) | {30'h0, rco, rov} << 16}, 32'h0002_0000);
        model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, rs, rco, rov);
        chk("model_7fff_plus_1", {32'(rs[15:0]) | {30'h0, rco, rov} << 16}, 32'h0001_8000);
        model(16, 64'h1234, 64'h4321, 1'b1, 1'b0, rs, rco, rov);
        chk("model_1234_plus_4321_c", {32'(rs[15:0]) | {30'h0, rco, rov} << 16}, 32'h0000_5556);
        model(16, 64'h0005, 64'h0007, 1'b0, 1'b1, rs, rco, rov);
        chk("model_5_minus_7", {32'(rs[15:0]) | {30'h0, rco, rov} << 16}, 32'h0000_FFFE);
        model(16, 64'h8000, 64'h0001, 1'b0, 1'b1, rs, rco, rov);
        chk("model_8000_minus_1", {32'(rs[15:0]) | {30'h0, rco, rov} << 16}, 32'h0003_7FFF);
        model(32, 64'h0000_0010, 64'h0000_0010, 1'b1, 1'b1, rs, rco, rov);
        chk("model32_borrow", 32'(rs), 32'hFFFF_FFFF);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) check_reset_state(i);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors on the 16/4 instance.
        run_op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(1, 32'h1234, 32'h4321, 1'b1, 1'b0, 0, 1'b0);
        run_op(1, 32'h0005, 32'h0007, 1'b0, 1'b1, 0, 1'b0);
        run_op(1, 32'h8000, 32'h0001, 1'b0, 1'b1, 0, 1'b0);

        // Backpressure with ignored input traffic while DONE.
        run_op(1, 32'h00FF, 32'h0F01, 1'b0, 1'b0, 5, 1'b1);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a_in = 32'hFFFF; b_in = 32'hFFFF; cin = 1'b1; sub_s = 1'b0;
        iv[1] = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state(1);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 32'h0001, 32'h0001, 1'b0, 1'b0, 0, 1'b0);
        chk("post_reset_sum_literal", exp_sum[1], 32'h0002);

        // Parameter sweep against the model.
        for (int i = 0; i < 5; i++) begin
            for (int n = 0; n < 1000; n++) begin
                run_op(i, pick(wid[i]), pick(wid[i]), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 15) == 0) ? 2 : 0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end
endmodule
